// File: rtl/mouse_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mouse_init_sequencer                                         |
// | Description : Runs the PS/2 mouse power-up sequence through ps2_host:      |
// |               reset (FF), BAT check, set sample rate (F3 + arg), enable    |
// |               reporting (F4). Every reply byte is checked. A NACK/resend   |
// |               (FE) resends the current command. A bad byte, a line error   |
// |               or a timeout restarts the sequence until MAX_RETRY restarts  |
// |               are used up. Once DONE, received bytes are forwarded as     |
// |               movement stream bytes.                                       |
// | Option      : MOUSE_INIT_SCROLL_EN adds the IntelliMouse knock (F3 C8,     |
// |               F3 64, F3 50, F2 -> ID) and a final F4 before DONE.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset          system clock, async active-high reset                |
// |   restart             1-cycle pulse, rerun the sequence, retries cleared   |
// |   busy                ps2_host transmitter busy                            |
// |   read, rx_data       received byte strobe and data                        |
// |   error               ps2_host frame/parity error strobe                   |
// |   write, tx_data      send request pulse and command byte                  |
// |   init_done/fail      sequence status                                      |
// |   retry_count         restarts consumed so far                             |
// |   stream_valid/data   forwarded rx bytes after DONE                        |
// |   wheel_present       scroll wheel detected                                |
// +----------------------------------------------------------------------------+
module mouse_init_sequencer #(
  parameter logic [7:0]  SAMPLE_RATE    = 8'd100,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       busy,
  input  logic       read,
  input  logic [7:0] rx_data,
  input  logic       error,
  output logic       write,
  output logic [7:0] tx_data,
  output logic       init_done,
  output logic       init_fail,
  output logic [3:0] retry_count,
  output logic       stream_valid,
  output logic [7:0] stream_data,
  output logic       wheel_present
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRY);
`ifdef MOUSE_INIT_SCROLL_EN
  localparam logic [3:0]         LAST_STEP   = 4'd11;
  localparam logic [3:0]         ID_STEP     = 4'd10;
`else
  localparam logic [3:0]         LAST_STEP   = 4'd3;
`endif

  typedef enum logic [2:0] {
    S_SEND  = 3'd0,
    S_WAIT  = 3'd1,
    S_RETRY = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [3:0]           step, step_n;
  logic [1:0]           reply_idx, reply_idx_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [3:0]           retry_n;
  logic [7:0]           tx_data_n;
  logic                 write_n;
  logic                 stream_valid_n;
  logic [7:0]           stream_data_n;
  logic                 reply_match;
  logic                 wheel_n;

  // Command byte sent at each step of the sequence.
  function automatic logic [7:0] cmd_byte(input logic [3:0] s);
    case (s)
      4'd0:    cmd_byte = 8'hFF;
      4'd1:    cmd_byte = 8'hF3;
      4'd2:    cmd_byte = SAMPLE_RATE;
`ifdef MOUSE_INIT_SCROLL_EN
      4'd4:    cmd_byte = 8'hF3;
      4'd5:    cmd_byte = 8'hC8;
      4'd6:    cmd_byte = 8'hF3;
      4'd7:    cmd_byte = 8'h64;
      4'd8:    cmd_byte = 8'hF3;
      4'd9:    cmd_byte = 8'h50;
      4'd10:   cmd_byte = 8'hF2;
`endif
      default: cmd_byte = 8'hF4;
    endcase
  endfunction

  // Index of the last reply byte expected for a step.
  function automatic logic [1:0] last_reply(input logic [3:0] s);
    last_reply = 2'd0;
    if (s == 4'd0) last_reply = 2'd2;
`ifdef MOUSE_INIT_SCROLL_EN
    if (s == ID_STEP) last_reply = 2'd1;
`endif
  endfunction

  // Reset replies with ACK, BAT pass, device ID; everything else just ACKs.
  function automatic logic [7:0] expected_reply(input logic [3:0] s, input logic [1:0] idx);
    expected_reply = 8'hFA;
    if (s == 4'd0 && idx == 2'd1) expected_reply = 8'hAA;
    if (s == 4'd0 && idx == 2'd2) expected_reply = 8'h00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_SEND;
      step         <= 4'd0;
      reply_idx    <= 2'd0;
      timer        <= '0;
      retry_count  <= 4'd0;
      tx_data      <= 8'h00;
      write        <= 1'b0;
      stream_valid <= 1'b0;
      stream_data  <= 8'h00;
    end else begin
      state        <= state_n;
      step         <= step_n;
      reply_idx    <= reply_idx_n;
      timer        <= timer_n;
      retry_count  <= retry_n;
      tx_data      <= tx_data_n;
      write        <= write_n;
      stream_valid <= stream_valid_n;
      stream_data  <= stream_data_n;
    end
  end

`ifdef MOUSE_INIT_SCROLL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wheel_present <= 1'b0;
    else       wheel_present <= wheel_n;
  end
`else
  assign wheel_present = 1'b0;
`endif

  always_comb begin
    state_n        = state;
    step_n         = step;
    reply_idx_n    = reply_idx;
    timer_n        = timer;
    retry_n        = retry_count;
    tx_data_n      = tx_data;
    write_n        = 1'b0;
    stream_valid_n = 1'b0;
    stream_data_n  = stream_data;
    wheel_n        = wheel_present;

    reply_match = (rx_data == expected_reply(step, reply_idx));
`ifdef MOUSE_INIT_SCROLL_EN
    // The ID reply decides wheel presence; 00 and 03 are both legal.
    if (step == ID_STEP && reply_idx == 2'd1)
      reply_match = (rx_data == 8'h03) || (rx_data == 8'h00);
`endif

    if (restart) begin
      // A transfer already on the wire is left alone; its reply lands in
      // SEND and is dropped there.
      state_n     = S_SEND;
      step_n      = 4'd0;
      reply_idx_n = 2'd0;
      timer_n     = '0;
      retry_n     = 4'd0;
      wheel_n     = 1'b0;
    end else begin
      case (state)
        S_SEND: begin
          if (!busy) begin
            tx_data_n   = cmd_byte(step);
            write_n     = 1'b1;
            timer_n     = '0;
            reply_idx_n = 2'd0;
            state_n     = S_WAIT;
          end
        end
        S_WAIT: begin
          if (error) begin
            state_n = S_RETRY;
          end else if (read) begin
            if (reply_match) begin
              timer_n = '0;
`ifdef MOUSE_INIT_SCROLL_EN
              if (step == ID_STEP && reply_idx == 2'd1) wheel_n = (rx_data == 8'h03);
`endif
              if (reply_idx == last_reply(step)) begin
                reply_idx_n = 2'd0;
                if (step == LAST_STEP) begin
                  state_n = S_DONE;
                end else begin
                  step_n  = step + 4'd1;
                  state_n = S_SEND;
                end
              end else begin
                reply_idx_n = reply_idx + 2'd1;
              end
            end else if (rx_data == 8'hFE) begin
              state_n = S_SEND;
            end else begin
              state_n = S_RETRY;
            end
          end else if (timer == TIMER_LAST) begin
            state_n = S_RETRY;
          end else begin
            timer_n = timer + TIMER_ONE;
          end
        end
        S_RETRY: begin
          if (retry_count == RETRY_LIMIT) begin
            state_n = S_FAIL;
          end else begin
            retry_n     = retry_count + 4'd1;
            step_n      = 4'd0;
            reply_idx_n = 2'd0;
            state_n     = S_SEND;
          end
        end
        S_DONE: begin
          if (read) begin
            stream_valid_n = 1'b1;
            stream_data_n  = rx_data;
          end
        end
        S_FAIL: begin
        end
        default: state_n = S_SEND;
      endcase
    end
  end

  assign init_done = (state == S_DONE);
  assign init_fail = (state == S_FAIL);

endmodule
`default_nettype wire

// File: tb/tb_mouse_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mouse_init_sequencer                                      |
// | Description : Directed self-checking bench for mouse_init_sequencer with   |
// |               TIMEOUT_CYCLES=1000. Honours MOUSE_INIT_SCROLL_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mouse_init_sequencer;

`ifdef MOUSE_INIT_SCROLL_EN
  localparam int NSTEP     = 12;
  localparam bit EXP_WHEEL = 1'b1;
`else
  localparam int NSTEP     = 4;
  localparam bit EXP_WHEEL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       busy = 1'b0;
  logic       read = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       error = 1'b0;
  logic       write;
  logic [7:0] tx_data;
  logic       init_done;
  logic       init_fail;
  logic [3:0] retry_count;
  logic       stream_valid;
  logic [7:0] stream_data;
  logic       wheel_present;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] seq_cmd [0:NSTEP-1];

  mouse_init_sequencer #(
    .SAMPLE_RATE(8'd100),
    .TIMEOUT_CYCLES(1000),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .busy(busy), .read(read),
    .rx_data(rx_data), .error(error), .write(write), .tx_data(tx_data),
    .init_done(init_done), .init_fail(init_fail), .retry_count(retry_count),
    .stream_valid(stream_valid), .stream_data(stream_data),
    .wheel_present(wheel_present)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    read = 1'b1; rx_data = b;
    tick();
    read = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // Wait (bounded) for a write pulse; report the byte and ticks waited.
  task automatic wait_write(input int budget, output logic [7:0] got, output bit found, output int n);
    got = 8'h00; found = 1'b0; n = 0;
    while (n < budget && !found) begin
      tick();
      n++;
      if (write === 1'b1) begin
        got = tx_data; found = 1'b1;
      end
    end
  endtask

  // Mouse model replies for each step of the sequence.
  task automatic answer_step(input int s);
    if (s == 0) begin
      send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
    end
`ifdef MOUSE_INIT_SCROLL_EN
    else if (s == 10) begin
      send_byte(8'hFA); send_byte(8'h03);
    end
`endif
    else begin
      send_byte(8'hFA);
    end
  endtask

  // Serves steps first..last; returns the number of unexpected commands.
  task automatic serve_steps(input int first, input int last, output int bad,
                             output logic [7:0] bad_got, output logic [7:0] bad_exp);
    logic [7:0] got; bit found; int n;
    bad = 0; bad_got = 8'h00; bad_exp = 8'h00;
    for (int s = first; s <= last; s++) begin
      wait_write(200, got, found, n);
      if (!found || got !== seq_cmd[s]) begin
        if (bad == 0) begin bad_got = got; bad_exp = seq_cmd[s]; end
        bad++;
        if (!found) return;
      end
      answer_step(s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; busy = 1'b1;
    tick(); tick();
    n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", write); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_checks++; if (init_done !== 1'b0 || init_fail !== 1'b0) begin n_fail++; $display("FAIL reset_status: got done=%b fail=%b expected 0 0", init_done, init_fail); end
    n_checks++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", retry_count); end
    n_checks++; if (stream_valid !== 1'b0 || stream_data !== 8'h00) begin n_fail++; $display("FAIL reset_stream: got valid=%b data=%h expected 0 00", stream_valid, stream_data); end
    n_checks++; if (wheel_present !== 1'b0) begin n_fail++; $display("FAIL reset_wheel: got %b expected 0", wheel_present); end
  endtask

  task automatic test_busy_hold();
    bit seen = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (write !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL busy_hold: got write=1 while busy expected 0"); end
    busy = 1'b0;
  endtask

  task automatic test_clean_init();
    int bad; logic [7:0] bg, be;
    serve_steps(0, NSTEP-1, bad, bg, be);
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clean_cmds: got %0d bad (first %h) expected 0 (first %h)", bad, bg, be); end
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL clean_done: got %b expected 1", init_done); end
    n_checks++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL clean_retry: got %0d expected 0", retry_count); end
    n_checks++; if (wheel_present !== EXP_WHEEL) begin n_fail++; $display("FAIL clean_wheel: got %b expected %b", wheel_present, EXP_WHEEL); end
  endtask

  task automatic test_stream();
    logic [7:0] bytes [0:2];
    bytes[0] = 8'h08; bytes[1] = 8'h05; bytes[2] = 8'hFB;
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i]);
      n_checks++; if (stream_valid !== 1'b1 || stream_data !== bytes[i]) begin n_fail++; $display("FAIL stream_byte%0d: got valid=%b data=%h expected 1 %h", i, stream_valid, stream_data, bytes[i]); end
      n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL stream_write%0d: got %b expected 0", i, write); end
      tick();
      n_checks++; if (stream_valid !== 1'b0) begin n_fail++; $display("FAIL stream_pulse%0d: got %b expected 0", i, stream_valid); end
    end
    error = 1'b1; tick(); error = 1'b0; tick();
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL stream_error_ignored: got done=%b expected 1", init_done); end
  endtask

  task automatic test_resend();
    int bad; logic [7:0] bg, be, got; bit found; int n;
    pulse_restart();
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL resend_restart_done: got %b expected 0", init_done); end
    serve_steps(0, 0, bad, bg, be);
    wait_write(200, got, found, n);
    n_checks++; if (!found || got !== 8'hF3) begin n_fail++; $display("FAIL resend_first: got %h expected F3", got); end
    send_byte(8'hFE);
    wait_write(200, got, found, n);
    n_checks++; if (!found || got !== 8'hF3) begin n_fail++; $display("FAIL resend_again: got %h expected F3", got); end
    answer_step(1);
    serve_steps(2, NSTEP-1, bad, bg, be);
    n_checks++; if (bad != 0 || init_done !== 1'b1 || retry_count !== 4'd0) begin n_fail++; $display("FAIL resend_end: got bad=%0d done=%b retry=%0d expected 0 1 0", bad, init_done, retry_count); end
  endtask

  task automatic test_bad_bat();
    int bad; logic [7:0] bg, be, got; bit found; int n;
    pulse_restart();
    wait_write(200, got, found, n);
    send_byte(8'hFA); send_byte(8'hFC);
    wait_write(200, got, found, n);
    n_checks++; if (!found || got !== 8'hFF) begin n_fail++; $display("FAIL badbat_cmd: got %h expected FF", got); end
    n_checks++; if (retry_count !== 4'd1) begin n_fail++; $display("FAIL badbat_retry: got %0d expected 1", retry_count); end
    answer_step(0);
    serve_steps(1, NSTEP-1, bad, bg, be);
    n_checks++; if (bad != 0 || init_done !== 1'b1 || retry_count !== 4'd1) begin n_fail++; $display("FAIL badbat_end: got bad=%0d done=%b retry=%0d expected 0 1 1", bad, init_done, retry_count); end
  endtask

  task automatic test_error_wins();
    logic [7:0] got; bit found; int n;
    pulse_restart();
    wait_write(200, got, found, n);
    read = 1'b1; rx_data = 8'hFA; error = 1'b1;
    tick();
    read = 1'b0; error = 1'b0;
    wait_write(200, got, found, n);
    n_checks++; if (!found || got !== 8'hFF || retry_count !== 4'd1) begin n_fail++; $display("FAIL error_wins: got cmd=%h retry=%0d expected FF 1", got, retry_count); end
  endtask

  task automatic test_restart_mid();
    int bad; logic [7:0] bg, be, got; bit found; int n; bit seen;
    pulse_restart();
    wait_write(200, got, found, n);
    send_byte(8'hFA); send_byte(8'hFC);
    wait_write(200, got, found, n);
    answer_step(0);
    serve_steps(1, 1, bad, bg, be);
    wait_write(200, got, found, n);
    n_checks++; if (!found || got !== 8'h64 || retry_count !== 4'd1) begin n_fail++; $display("FAIL restart_step2: got cmd=%h retry=%0d expected 64 1", got, retry_count); end
    busy = 1'b1;
    tick(); tick(); tick();
    pulse_restart();
    send_byte(8'hFA);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (write !== 1'b0) seen = 1'b1; end
    n_checks++; if (seen || retry_count !== 4'd0) begin n_fail++; $display("FAIL restart_hold: got write_seen=%b retry=%0d expected 0 0", seen, retry_count); end
    busy = 1'b0;
    wait_write(200, got, found, n);
    n_checks++; if (!found || got !== 8'hFF) begin n_fail++; $display("FAIL restart_cmd: got %h expected FF", got); end
    answer_step(0);
    serve_steps(1, NSTEP-1, bad, bg, be);
    n_checks++; if (bad != 0 || init_done !== 1'b1 || retry_count !== 4'd0) begin n_fail++; $display("FAIL restart_end: got bad=%0d done=%b retry=%0d expected 0 1 0", bad, init_done, retry_count); end
    n_checks++; if (wheel_present !== EXP_WHEEL) begin n_fail++; $display("FAIL restart_wheel: got %b expected %b", wheel_present, EXP_WHEEL); end
  endtask

  task automatic test_timeout();
    logic [7:0] got; bit found; int n; bit seen;
    pulse_restart();
    wait_write(200, got, found, n);
    for (int t = 1; t <= 3; t++) begin
      wait_write(1100, got, found, n);
      n_checks++; if (!found || got !== 8'hFF) begin n_fail++; $display("FAIL timeout_cmd%0d: got %h expected FF", t, got); end
      n_checks++; if (n < 1000 || n > 1010) begin n_fail++; $display("FAIL timeout_gap%0d: got %0d cycles expected 1000..1010", t, n); end
      n_checks++; if (retry_count !== 4'(t)) begin n_fail++; $display("FAIL timeout_retry%0d: got %0d expected %0d", t, retry_count, t); end
    end
    n = 0;
    while (n < 1100 && init_fail !== 1'b1) begin tick(); n++; end
    n_checks++; if (init_fail !== 1'b1 || retry_count !== 4'd3 || init_done !== 1'b0) begin n_fail++; $display("FAIL timeout_fail: got fail=%b retry=%0d done=%b expected 1 3 0", init_fail, retry_count, init_done); end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      read = (i % 7 == 0); rx_data = 8'hFA; error = (i % 11 == 0);
      tick();
      if (write !== 1'b0 || init_fail !== 1'b1) seen = 1'b1;
    end
    read = 1'b0; error = 1'b0;
    n_checks++; if (seen) begin n_fail++; $display("FAIL fail_hold: got write or exit from FAIL expected held"); end
    pulse_restart();
    n_checks++; if (init_fail !== 1'b0 || retry_count !== 4'd0) begin n_fail++; $display("FAIL fail_restart: got fail=%b retry=%0d expected 0 0", init_fail, retry_count); end
    wait_write(200, got, found, n);
    n_checks++; if (!found || got !== 8'hFF) begin n_fail++; $display("FAIL fail_restart_cmd: got %h expected FF", got); end
  endtask

  initial begin
    seq_cmd[0] = 8'hFF; seq_cmd[1] = 8'hF3; seq_cmd[2] = 8'h64; seq_cmd[3] = 8'hF4;
`ifdef MOUSE_INIT_SCROLL_EN
    seq_cmd[4] = 8'hF3; seq_cmd[5] = 8'hC8; seq_cmd[6] = 8'hF3; seq_cmd[7]  = 8'h64;
    seq_cmd[8] = 8'hF3; seq_cmd[9] = 8'h50; seq_cmd[10] = 8'hF2; seq_cmd[11] = 8'hF4;
`endif
    test_reset();
    test_busy_hold();
    test_clean_init();
    test_stream();
    test_resend();
    test_bad_bat();
    test_error_wins();
    test_restart_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
